wb_intercon: RTL and testbench



---
 rtl/wb_intercon.sv | 136 +++++++++++++
 tb/tb_wb_intercon.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon.sv
// wb_intercon: two-master, N-slave Wishbone shared-bus interconnect.
// Round-robin grant held for a master's whole cyc. Slaves are decoded on the top S_ADDR_W address
// bits. Unmapped accesses return a one-cycle registered err.
// Optional watchdog: define WB_INTERCON_TIMEOUT_EN to raise err after TIMEOUT_CYCLES stalled cycles.
module wb_intercon #(
    parameter int unsigned                       N_SLAVES       = 6,
    parameter int unsigned                       S_ADDR_W       = 3,
    parameter logic [N_SLAVES*S_ADDR_W-1:0]      SLAVE_ADDRS    = {3'b110, 3'b101, 3'b100,
                                                                   3'b010, 3'b011, 3'b000},
    parameter int unsigned                       TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [31:0]            m0_adr_i,
    input  logic [31:0]            m0_dat_i,
    input  logic [3:0]             m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    output logic [31:0]            m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic [31:0]            m1_adr_i,
    input  logic [31:0]            m1_dat_i,
    input  logic [3:0]             m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    output logic [31:0]            m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic [3:0]             s_sel_o,
    output logic                   s_we_o,
    output logic [N_SLAVES-1:0]    s_cyc_o,
    output logic [N_SLAVES-1:0]    s_stb_o,
    input  logic [N_SLAVES-1:0]    s_ack_i,
    input  logic [32*N_SLAVES-1:0] s_dat_i
);

    logic                r_owner;     // 0: m0 holds the bus, 1: m1
    logic                r_err;       // registered error pulse for the current owner

    logic                w_cyc;
    logic                w_stb;
    logic [31:0]         w_adr;
    logic                w_switch;
    logic [N_SLAVES-1:0] w_hit_oh;
    logic                w_hit_any;
    logic                w_slave_ack;
    logic [31:0]         w_rdata;
    logic                w_ack;
    logic                w_unmapped;
    logic                w_timeout;

    // Owner's request drives the shared slave bus.
    assign w_cyc   = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_stb   = r_owner ? m1_stb_i : m0_stb_i;
    assign w_adr   = r_owner ? m1_adr_i : m0_adr_i;
    assign s_adr_o = w_adr;
    assign s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
    assign s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
    assign s_we_o  = r_owner ? m1_we_i  : m0_we_i;

    // Hand the bus over only when the owner is idle and the other master is asking.
    assign w_switch = r_owner ? (~m1_cyc_i & m0_cyc_i) : (~m0_cyc_i & m1_cyc_i);

    // Priority decode (lowest index wins) plus ack/read-data mux of the selected slave.
    always_comb begin
        w_hit_oh    = '0;
        w_hit_any   = 1'b0;
        w_slave_ack = 1'b0;
        w_rdata     = 32'h0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (!w_hit_any && (w_adr[31 -: S_ADDR_W] == SLAVE_ADDRS[k*S_ADDR_W +: S_ADDR_W])) begin
                w_hit_oh[k] = 1'b1;
                w_hit_any   = 1'b1;
                w_slave_ack = s_ack_i[k];
                w_rdata     = s_dat_i[32*k +: 32];
            end
        end
    end

    // The strobe is held off during an error cycle so the slave does not see a dangling access.
    assign s_cyc_o = {N_SLAVES{rst & w_cyc}} & w_hit_oh;
    assign s_stb_o = {N_SLAVES{rst & w_cyc & w_stb & ~r_err}} & w_hit_oh;

    assign w_ack      = w_cyc & w_stb & ~r_err & w_slave_ack;
    // No re-raise while a pulse is showing, so errors stay single-cycle.
    assign w_unmapped = w_cyc & w_stb & ~w_hit_any & ~r_err;

    assign m0_dat_o = w_rdata;
    assign m1_dat_o = w_rdata;
    assign m0_ack_o = rst & ~r_owner & w_ack;
    assign m1_ack_o = rst &  r_owner & w_ack;
    assign m0_err_o = rst & ~r_owner & r_err;
    assign m1_err_o = rst &  r_owner & r_err;

`ifdef WB_INTERCON_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        w_stall;

    // An ack in the limit cycle excludes it from the stall, so ack wins over timeout.
    assign w_stall   = w_cyc & w_stb & w_hit_any & ~w_ack & ~r_err;
    assign w_timeout = w_stall & (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts unanswered strobe cycles, restarts on any termination or handover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 16'h0;
        end else if (w_switch || !w_stall || w_timeout) begin
            r_cnt <= 16'h0;
        end else begin
            r_cnt <= r_cnt + 16'h1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Grant and error-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_owner <= r_owner ^ w_switch;
            r_err   <= w_unmapped | w_timeout;
        end
    end

endmodule

// File: tb/tb_wb_intercon.sv
// Directed self-checking bench for wb_intercon (6 slaves, TIMEOUT_CYCLES = 16).
// Slave k returns read data 0xD000000k, except slave 4, which returns 0xCAFEF00D.
// Decode: 0x0->s0, 0x6->s1 (uart), 0x4/0x5->s2, 0x8/0x9->s3, 0xA/0xB->s4, 0xC/0xD->s5.
module tb_wb_intercon;

    localparam int unsigned NS = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0]   m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o;
    logic [NS-1:0] s_cyc_o, s_stb_o, s_ack_i;
    logic [32*NS-1:0] s_dat_i;

    int n_pass;
    int n_total;
    logic early;

    wb_intercon #(
        .N_SLAVES       (NS),
        .S_ADDR_W       (3),
        .SLAVE_ADDRS    ({3'b110, 3'b101, 3'b100, 3'b010, 3'b011, 3'b000}),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_sel_i (m0_sel_i),
        .m0_we_i  (m0_we_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_sel_i (m1_sel_i),
        .m1_we_i  (m1_we_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_ack_i  (s_ack_i),
        .s_dat_i  (s_dat_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Step to 1 time unit past the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        early    = 1'b0;
        rst      = 1'b0;
        m0_dat_i = 32'h0;  m0_sel_i = 4'hF;  m0_we_i = 1'b0;
        m1_dat_i = 32'h0;  m1_sel_i = 4'hF;  m1_we_i = 1'b0;
        for (int k = 0; k < NS; k++) s_dat_i[32*k +: 32] = 32'hD000_0000 | k;
        s_dat_i[32*4 +: 32] = 32'hCAFE_F00D;

        // Reset held while both masters request and slaves 0/3 ack.
        m0_adr_i = 32'h0000_0040;  m0_cyc_i = 1'b1;  m0_stb_i = 1'b1;
        m1_adr_i = 32'h8000_0000;  m1_cyc_i = 1'b1;  m1_stb_i = 1'b1;
        s_ack_i  = 6'b001001;
        nxt(); nxt(); settle();
        chk("rst_s_cyc",  32'(s_cyc_o), 32'h0);
        chk("rst_s_stb",  32'(s_stb_o), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("rst_m1_ack", 32'(m1_ack_o), 32'h0);
        chk("rst_m0_err", 32'(m0_err_o), 32'h0);

        // Release: owner restarts at m0.
        s_ack_i = 6'b000000;
        rst     = 1'b1;
        settle();
        chk("rel_owner0_stb", 32'(s_stb_o), 32'h01);
        chk("rel_adr",        s_adr_o,      32'h0000_0040);
        s_ack_i = 6'b001001;
        settle();
        chk("arb_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("arb_m0_dat", m0_dat_o,      32'hD000_0000);
        chk("arb_m1_ack", 32'(m1_ack_o), 32'h0);

        // m0 drops cyc: one dead cycle, then m1 gets the slave.
        nxt(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; settle();
        chk("arb_gap_stb", 32'(s_stb_o), 32'h0);
        chk("arb_gap_ack", 32'(m1_ack_o), 32'h0);
        nxt(); settle();
        chk("arb_m1_stb", 32'(s_stb_o), 32'h08);
        chk("arb_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("arb_m1_dat", m1_dat_o,      32'hD000_0003);

        // m0 re-requests during m1's cyc and must wait.
        nxt(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; settle();
        chk("wait1_stb",    32'(s_stb_o), 32'h08);
        chk("wait1_m0_ack", 32'(m0_ack_o), 32'h0);
        nxt(); settle();
        chk("wait2_stb", 32'(s_stb_o), 32'h08);
        nxt(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();
        chk("m1_drop_stb", 32'(s_stb_o), 32'h0);
        nxt(); settle();
        chk("m0_regain_stb", 32'(s_stb_o), 32'h01);
        chk("m0_regain_ack", 32'(m0_ack_o), 32'h1);
        nxt(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 6'b000000; settle();

        // Decode: m1 reads slave 4 (top bits 101).
        nxt();
        m1_adr_i = 32'hA000_0010; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 6'b010000;
        settle();
        chk("dec_pre_stb", 32'(s_stb_o), 32'h0);
        chk("dec_pre_ack", 32'(m1_ack_o), 32'h0);
        nxt(); settle();
        chk("dec_stb",    32'(s_stb_o), 32'h10);
        chk("dec_cyc",    32'(s_cyc_o), 32'h10);
        chk("dec_m1_dat", m1_dat_o,      32'hCAFE_F00D);
        chk("dec_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("dec_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("dec_m0_dat", m0_dat_o,      32'hCAFE_F00D);

        // Write to slave 2 (0x50000010) within the same cyc.
        nxt();
        m1_adr_i = 32'h5000_0010; m1_we_i = 1'b1; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'b0011;
        s_ack_i  = 6'b000000;
        settle();
        chk("wr_stb",     32'(s_stb_o), 32'h04);
        chk("wr_we",      32'(s_we_o),  32'h1);
        chk("wr_dat",     s_dat_o,      32'h1234_5678);
        chk("wr_sel",     32'(s_sel_o), 32'h3);
        chk("wr_noack",   32'(m1_ack_o), 32'h0);
        s_ack_i = 6'b000100;
        settle();
        chk("wr_ack", 32'(m1_ack_o), 32'h1);
        nxt();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'hF; s_ack_i = 6'b000000;
        settle();
        chk("dec_ack_gone", 32'(m1_ack_o), 32'h0);

        // Unmapped: m0 to 0xE0000000 (owner is m1, so one cycle for the handover).
        nxt(); m0_adr_i = 32'hE000_0000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; settle();
        nxt(); settle();
        chk("unm_nostb",     32'(s_stb_o), 32'h0);
        chk("unm_nocyc",     32'(s_cyc_o), 32'h0);
        chk("unm_err_early", 32'(m0_err_o), 32'h0);
        nxt(); settle();
        chk("unm_err",    32'(m0_err_o), 32'h1);
        chk("unm_m1_err", 32'(m1_err_o), 32'h0);
        nxt(); settle();
        chk("unm_pulse1", 32'(m0_err_o), 32'h0);
        nxt(); settle();
        chk("unm_reraise", 32'(m0_err_o), 32'h1);
        nxt(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; settle();
        chk("unm_idle_err", 32'(m0_err_o), 32'h0);

        // Stalled uart (slave 1, 0x6xxxxxxx) accessed by m1; slave never acks.
        nxt(); m1_adr_i = 32'h6000_0000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; settle();
        nxt(); settle();
        chk("to_stb", 32'(s_stb_o), 32'h02);
`ifdef WB_INTERCON_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            if (m1_err_o !== 1'b0) early = 1'b1;
            nxt();
        end
        chk("to_no_early", 32'(early),    32'h0);
        chk("to_err",      32'(m1_err_o), 32'h1);
        chk("to_suppress", 32'(s_stb_o),  32'h0);
        chk("to_no_ack",   32'(m1_ack_o), 32'h0);
        nxt();
        chk("to_pulse1", 32'(m1_err_o), 32'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            if (m1_err_o !== 1'b0) early = 1'b1;
            nxt();
        end
        chk("hang_no_err", 32'(early),   32'h0);
        chk("hang_stb",    32'(s_stb_o), 32'h02);
`endif
        nxt(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();

        // Ack arriving in the 16th stalled cycle: ack wins, no err.
        nxt(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; settle();
        for (int i = 1; i < 16; i++) nxt();
        s_ack_i = 6'b000010;
        settle();
        chk("ackwin_ack", 32'(m1_ack_o), 32'h1);
        chk("ackwin_err", 32'(m1_err_o), 32'h0);
        nxt(); s_ack_i = 6'b000000; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();
        chk("ackwin_no_late_err", 32'(m1_err_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
